quarter_rom_arbiter: RTL and testbench
======================================

# quarter_rom_arbiter

Shares the single 128-entry quarter-wave sine ROM (`mem`) between `N_CH` waveform channels. Each channel requests a full-wave sample by 9-bit phase. The block arbitrates one request per cycle, folds the phase onto a quarter-wave ROM address, and reconstructs the full-wave 8-bit sample. The result is returned tagged with the requesting channel. It sits between the per-channel phase generators and the shared ROM, replacing per-channel ROM copies.

## Interface
- `N_CH`, 2, number of requesting channels (2..8)
- `clk`  in  1  system clock, all logic rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  N_CH  per-channel request; held until granted
- `phase`  in  9*N_CH  packed; channel k at [9k+8:9k]; bits [8:7] quadrant, [6:0] index
- `gnt`  out  N_CH  one-hot grant, combinational from `req` and pointer; transfer = `req[k] & gnt[k]`
- `rom_addr`  out  7  address to synchronous ROM (1-cycle read latency)
- `rom_data`  in  8  ROM output, valid the cycle after `rom_addr`
- `out_valid`  out  1  sample valid strobe, one cycle per accepted request
- `out_ch`  out  3  channel of current sample
- `out_sample`  out  8  reconstructed full-wave sample

## Operation
- Arbitration (default round-robin):
  - Search starts at `last+1` mod `N_CH`.
  - The first asserted `req` is granted.
  - `last` updates to the granted channel on transfer.
  - At most one `gnt` bit is high per cycle.
  - `gnt` is all-zero when `req` is zero.
- Phase folding by quadrant `q`, index `i`:
  - q=0: addr=`i`, sample=data
  - q=1: addr=`127-i`, sample=data
  - q=2: addr=`i`, sample=`(256-data) mod 256`
  - q=3: addr=`127-i`, sample=`(256-data) mod 256`
- Arithmetic is 8-bit unsigned. `256-data` is computed as two's-complement negate. data=0 in q2/q3 gives 0 (no saturation).
- Pipeline, no stalls, accepts one transfer per cycle:
  - S1: register ch, quadrant, folded address. `rom_addr` is driven from the S1 register.
  - S2: ROM returns data. Ch and quadrant are delayed alongside.
  - S3: register `out_sample`, `out_ch`, `out_valid`.
- Downstream has no backpressure; consumers must accept every `out_valid`.
- Requester drops `req[k]` in the cycle after its transfer, or keeps it high for back-to-back samples. It then competes again under round-robin.
- Simultaneous `req` on all channels gives grants in strict rotation 0,1,..,N_CH-1,0,…

## Timing
- Reset values:
  - `gnt` = 0 while `rst` is high.
  - `rom_addr` = 0.
  - `out_valid` = 0, `out_ch` = 0, `out_sample` = 0.
  - `last` = `N_CH-1`, so channel 0 wins first.
  - Pipeline valid bits are cleared.
- Latency: transfer in cycle t gives `rom_addr` valid in t+1, `rom_data` in t+2, and `out_valid` high in t+3.
- Throughput: one sample per cycle sustained, with no bubbles between channels.
- Reset mid-operation: all in-flight samples are discarded. No `out_valid` occurs until 3 cycles after a new transfer following reset release.
- Phase wrap 9'h1FF→9'h000 needs no special case; it is handled by the folding.
- Index 127 in q1/q3 gives addr 0. Index 0 in q1/q3 gives addr 127.

## Configuration
- `QROM_FIXED_PRIO_EN` defined: fixed priority. The lowest-numbered asserted `req` always wins, and `last` is unused.
- `QROM_FIXED_PRIO_EN` undefined: round-robin as above.
- Pipeline, latency and folding are identical in both builds.

## Structure
- Package `qrom_pkg`:
  - `IDX_W`=7, `DATA_W`=8, `LUT_MAX`=127
  - quadrant enum `Q_RISE`, `Q_FALL`, `Q_NRISE`, `Q_NFALL`
  - function `fold_addr(q,i)` and function `fold_sample(q,d)`
- Sub-module `rr_arbiter`, parameterized by `N_CH`:
  - round-robin pointer and one-hot grant
  - contains the `QROM_FIXED_PRIO_EN` switch
- Top instantiates `rr_arbiter` plus the 3-stage pipeline. The ROM stays outside the block.

## Test plan
- Reset then single request: ch0 `req` with phase 9'h005 (q0,i5), ROM returns model[5] → `out_valid` at t+3, `out_ch`=0, `out_sample`=model[5].
- Folding: ch1 phases 9'h085, 9'h105, 9'h185 back-to-back → `rom_addr` 122, 5, 122; samples model[122], 256-model[5], 256-model[122]; three consecutive `out_valid`.
- Zero boundary: q2 index with model value 0 → `out_sample`=8'h00; q1 index 127 → `rom_addr`=0.
- Contention, N_CH=3, all `req` held 6 cycles → grants 0,1,2,0,1,2, `out_ch` same order, no gaps. With `QROM_FIXED_PRIO_EN` → six grants to ch0.
- Async reset asserted mid-stream with 2 samples in flight → outputs zero immediately, no stale `out_valid` after release. The first post-reset grant goes to ch0.
- Sweep: ch0 steps phase 0..511 continuously → output matches the full-wave model with period 512, and 9'h1FF→9'h000 is continuous.

Source files
------------

// File: rtl/qrom_pkg.sv
// Shared types and folding helpers for the quarter-wave sine ROM arbiter.
package qrom_pkg;

  localparam int IDX_W   = 7;
  localparam int DATA_W  = 8;
  localparam int LUT_MAX = 127;
  localparam int PH_W    = 9;
  localparam int CH_W    = 3;

  typedef enum logic [1:0] {
    Q_RISE  = 2'd0,
    Q_FALL  = 2'd1,
    Q_NRISE = 2'd2,
    Q_NFALL = 2'd3
  } quad_e;

  // Falling quadrants read the table mirrored.
  function automatic logic [IDX_W-1:0] fold_addr(input quad_e q, input logic [IDX_W-1:0] i);
    if (q == Q_FALL || q == Q_NFALL) return IDX_W'(LUT_MAX) - i;
    return i;
  endfunction

  // Negative half-wave is a plain 8-bit two's-complement negate, so 0 stays 0.
  function automatic logic [DATA_W-1:0] fold_sample(input quad_e q, input logic [DATA_W-1:0] d);
    if (q == Q_NRISE || q == Q_NFALL) return ~d + DATA_W'(1);
    return d;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant over N_CH requesters; round-robin by default,
// fixed lowest-index priority when QROM_FIXED_PRIO_EN is defined.
module rr_arbiter
  import qrom_pkg::*;
#(
  parameter int N_CH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   req,
  output logic [N_CH-1:0]   gnt,
  output logic [CH_W-1:0]   gnt_ch
);

  logic [N_CH-1:0] gnt_raw;
  logic [CH_W-1:0] ch_raw;
  logic            found;

`ifdef QROM_FIXED_PRIO_EN
  always_comb begin
    gnt_raw = '0;
    ch_raw  = '0;
    found   = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (!found && req[k]) begin
        gnt_raw[k] = 1'b1;
        ch_raw     = CH_W'(k);
        found      = 1'b1;
      end
    end
  end
`else
  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [PTR_W-1:0] last_q, last_d;

  // Scan offsets 1..N_CH from the last winner; the first live request wins.
  always_comb begin
    gnt_raw = '0;
    ch_raw  = '0;
    found   = 1'b0;
    for (int o = 1; o <= N_CH; o++) begin
      for (int k = 0; k < N_CH; k++) begin
        if (!found && req[k] && (k == (int'(last_q) + o) % N_CH)) begin
          gnt_raw[k] = 1'b1;
          ch_raw     = CH_W'(k);
          found      = 1'b1;
        end
      end
    end
    last_d = found ? PTR_W'(ch_raw) : last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= PTR_W'(N_CH - 1);
    else     last_q <= last_d;
  end
`endif

  assign gnt    = rst ? '0 : gnt_raw;
  assign gnt_ch = ch_raw;

endmodule

// File: rtl/quarter_rom_arbiter.sv
// Shares one quarter-wave sine ROM among N_CH channels: arbitrate, fold
// phase to ROM address, rebuild the full-wave sample three cycles later.
module quarter_rom_arbiter
  import qrom_pkg::*;
#(
  parameter int N_CH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        req,
  input  logic [PH_W*N_CH-1:0]   phase,
  output logic [N_CH-1:0]        gnt,
  output logic [IDX_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]      rom_data,
  output logic                   out_valid,
  output logic [CH_W-1:0]        out_ch,
  output logic [DATA_W-1:0]      out_sample
);

  logic [CH_W-1:0] gnt_ch;
  logic            xfer;
  logic [PH_W-1:0] sel_ph;
  quad_e           sel_quad;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .gnt_ch (gnt_ch)
  );

  always_comb begin
    sel_ph = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt[k]) sel_ph = phase[PH_W*k +: PH_W];
    end
  end

  assign xfer     = |(req & gnt);
  assign sel_quad = quad_e'(sel_ph[PH_W-1:IDX_W]);

  logic              s1_vld_q, s1_vld_d;
  logic [CH_W-1:0]   s1_ch_q, s1_ch_d;
  quad_e             s1_quad_q, s1_quad_d;
  logic [IDX_W-1:0]  s1_addr_q, s1_addr_d;
  logic              s2_vld_q, s2_vld_d;
  logic [CH_W-1:0]   s2_ch_q, s2_ch_d;
  quad_e             s2_quad_q, s2_quad_d;
  logic              out_valid_q, out_valid_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [DATA_W-1:0] out_sample_q, out_sample_d;

  always_comb begin
    s1_vld_d     = xfer;
    s1_ch_d      = xfer ? gnt_ch : s1_ch_q;
    s1_quad_d    = xfer ? sel_quad : s1_quad_q;
    s1_addr_d    = xfer ? fold_addr(sel_quad, sel_ph[IDX_W-1:0]) : s1_addr_q;
    // ROM data arrives while S2 holds the matching channel and quadrant.
    s2_vld_d     = s1_vld_q;
    s2_ch_d      = s1_ch_q;
    s2_quad_d    = s1_quad_q;
    out_valid_d  = s2_vld_q;
    out_ch_d     = s2_vld_q ? s2_ch_q : out_ch_q;
    out_sample_d = s2_vld_q ? fold_sample(s2_quad_q, rom_data) : out_sample_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q     <= 1'b0;
      s1_ch_q      <= '0;
      s1_quad_q    <= Q_RISE;
      s1_addr_q    <= '0;
      s2_vld_q     <= 1'b0;
      s2_ch_q      <= '0;
      s2_quad_q    <= Q_RISE;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_sample_q <= '0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_ch_q      <= s1_ch_d;
      s1_quad_q    <= s1_quad_d;
      s1_addr_q    <= s1_addr_d;
      s2_vld_q     <= s2_vld_d;
      s2_ch_q      <= s2_ch_d;
      s2_quad_q    <= s2_quad_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      out_sample_q <= out_sample_d;
    end
  end

  assign rom_addr   = s1_addr_q;
  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign out_sample = out_sample_q;

endmodule

// File: tb/tb_quarter_rom_arbiter.sv
// Directed scoreboard bench for quarter_rom_arbiter with N_CH=3 and a behavioural ROM.
module tb_quarter_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req;
  logic [26:0] phase;
  logic [2:0]  gnt;
  logic [6:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        out_valid;
  logic [2:0]  out_ch;
  logic [7:0]  out_sample;

  quarter_rom_arbiter #(.N_CH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .phase      (phase),
    .gnt        (gnt),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .out_valid  (out_valid),
    .out_ch     (out_ch),
    .out_sample (out_sample)
  );

  always #5 clk = ~clk;

  // Table content is a bijection on 0..127 with entry 0 = 0.
  logic [7:0] rom_tbl [128];
  always @(posedge clk) rom_data <= rom_tbl[rom_addr];

  typedef struct {
    int         cyc;
    logic [7:0] val;
    logic [2:0] ch;
  } exp_t;

  exp_t addr_q[$];
  exp_t samp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_addr(input logic [8:0] ph);
    int q, i, a;
    q = int'(ph[8:7]);
    i = int'(ph[6:0]);
    a = (q % 2 == 1) ? 127 - i : i;
    return 7'(a);
  endfunction

  function automatic logic [7:0] exp_sample(input logic [8:0] ph);
    int d;
    d = int'(rom_tbl[exp_addr(ph)]);
    if (ph[8]) d = (256 - d) % 256;
    return 8'(d);
  endfunction

  function automatic logic [2:0] exp_rot(input int n);
`ifdef QROM_FIXED_PRIO_EN
    return (n >= 0) ? 3'b001 : 3'b000;
`else
    return 3'b001 << (n % 3);
`endif
  endfunction

  task automatic push(input logic [2:0] ch, input logic [8:0] ph);
    exp_t e;
    e.ch  = ch;
    e.cyc = cyc + 1;
    e.val = {1'b0, exp_addr(ph)};
    addr_q.push_back(e);
    e.cyc = cyc + 3;
    e.val = exp_sample(ph);
    samp_q.push_back(e);
  endtask

  task automatic drive(input logic [2:0] r, input logic [8:0] p0, input logic [8:0] p1,
                       input logic [8:0] p2, input logic [2:0] eg, input string tag);
    logic [2:0] hit;
    req   = r;
    phase = {p2, p1, p0};
    @(negedge clk);
    chk(tag, 16'(gnt), 16'(eg));
    hit = eg & r;
    case (hit)
      3'b001:  push(3'd0, p0);
      3'b010:  push(3'd1, p1);
      3'b100:  push(3'd2, p2);
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (addr_q.size() > 0 && addr_q[0].cyc == cyc) begin
      e = addr_q.pop_front();
      chk("rom_addr", 16'(rom_addr), 16'(e.val));
    end
    if (out_valid === 1'b1) begin
      if (samp_q.size() == 0) begin
        chk("stray_out_valid", 16'(out_valid), 16'(0));
      end else begin
        e = samp_q.pop_front();
        chk("out_latency", 16'(cyc), 16'(e.cyc));
        chk("out_ch", 16'(out_ch), 16'(e.ch));
        chk("out_sample", 16'(out_sample), 16'(e.val));
      end
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) rom_tbl[i] = 8'((i * 37) % 128);
    req   = 3'b000;
    phase = '0;
    rst   = 1'b1;

    // Reset state, with requests present.
    #2;
    req = 3'b111;
    #1;
    chk("rst_gnt", 16'(gnt), 16'(0));
    chk("rst_out_valid", 16'(out_valid), 16'(0));
    chk("rst_out_ch", 16'(out_ch), 16'(0));
    chk("rst_out_sample", 16'(out_sample), 16'(0));
    chk("rst_rom_addr", 16'(rom_addr), 16'(0));
    req = 3'b000;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request on ch0.
    drive(3'b001, 9'h005, 9'h000, 9'h000, 3'b001, "gnt_single");
    for (int n = 0; n < 4; n++) drive(3'b000, 9'h0, 9'h0, 9'h0, 3'b000, "gnt_idle");

    // Folding through all quadrants, back-to-back on ch1.
    drive(3'b010, 9'h000, 9'h085, 9'h000, 3'b010, "gnt_fold_q1");
    drive(3'b010, 9'h000, 9'h105, 9'h000, 3'b010, "gnt_fold_q2");
    drive(3'b010, 9'h000, 9'h185, 9'h000, 3'b010, "gnt_fold_q3");

    // Zero and address boundaries.
    drive(3'b100, 9'h000, 9'h000, 9'h100, 3'b100, "gnt_zero_q2");
    drive(3'b001, 9'h0FF, 9'h000, 9'h000, 3'b001, "gnt_q1_i127");
    drive(3'b001, 9'h180, 9'h000, 9'h000, 3'b001, "gnt_q3_i0");
    drive(3'b100, 9'h000, 9'h000, 9'h00A, 3'b100, "gnt_ch2_only");

    // Contention: all channels held for six cycles.
    for (int n = 0; n < 6; n++)
      drive(3'b111, 9'h033, 9'h0C4, 9'h1A7, exp_rot(n), "gnt_contention");
    for (int n = 0; n < 4; n++) drive(3'b000, 9'h0, 9'h0, 9'h0, 3'b000, "gnt_idle");

    // Reset with two samples in flight.
    drive(3'b111, 9'h011, 9'h122, 9'h033, exp_rot(0), "gnt_pre_rst0");
    drive(3'b111, 9'h011, 9'h122, 9'h033, exp_rot(1), "gnt_pre_rst1");
    req = 3'b000;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 16'(out_valid), 16'(0));
    chk("midrst_out_ch", 16'(out_ch), 16'(0));
    chk("midrst_out_sample", 16'(out_sample), 16'(0));
    chk("midrst_rom_addr", 16'(rom_addr), 16'(0));
    chk("midrst_gnt", 16'(gnt), 16'(0));
    addr_q.delete();
    samp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 5; n++) drive(3'b000, 9'h0, 9'h0, 9'h0, 3'b000, "gnt_post_rst_idle");
    drive(3'b111, 9'h044, 9'h055, 9'h066, 3'b001, "gnt_post_rst_first");

    // Continuous phase sweep on ch0, including the 1FF -> 000 wrap.
    for (int p = 0; p <= 512; p++)
      drive(3'b001, 9'(p % 512), 9'h000, 9'h000, 3'b001, "gnt_sweep");
    for (int n = 0; n < 6; n++) drive(3'b000, 9'h0, 9'h0, 9'h0, 3'b000, "gnt_idle");

    chk("sb_drain_addr", 16'(addr_q.size()), 16'(0));
    chk("sb_drain_samp", 16'(samp_q.size()), 16'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
